// File: rtl/mlp_job_scheduler.sv
// Two-requester round-robin job scheduler in front of mlp_top: loads one 2x2 weight tile and
// NUM_ACT_ROWS activation words per job, starts the MLP and reports done or timeout.
module mlp_job_scheduler #(
    parameter int NUM_ACT_ROWS   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      req_valid,
    output logic [1:0]                      req_ready,
    input  logic [1:0][31:0]                req_weights,
    input  logic [1:0][16*NUM_ACT_ROWS-1:0] req_acts,
    output logic                            wf_reset,
    output logic                            wf_push_col0,
    output logic                            wf_push_col1,
    output logic [7:0]                      wf_data_in,
    output logic                            init_act_valid,
    output logic [15:0]                     init_act_data,
    output logic                            start_mlp,
    output logic                            weights_ready,
    input  logic [3:0]                      mlp_state,
    input  logic                            layer_complete,
    output logic                            mlp_reset,
    output logic                            done_valid,
    output logic                            done_id,
    output logic                            done_timeout,
    output logic                            busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (NUM_ACT_ROWS > 4) ? $clog2(NUM_ACT_ROWS) : 2;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_PUSH, S_ACT, S_START, S_WAIT, S_DONE, S_DRAIN, S_ABORT
    } state_t;

    state_t                         state, state_n;
    logic [IW-1:0]                  idx, idx_n;
    logic [TW-1:0]                  tcnt, tcnt_n, tcnt_inc;
    logic                           last_grant, job_id, grant, accept;
    logic signed [7:0]              w_q [4];
    logic [NUM_ACT_ROWS-1:0][15:0]  acts_q;

    always_comb begin
        grant    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        accept   = (state == S_IDLE) && (req_valid != 2'b00) && !reset;
        tcnt_inc = tcnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            tcnt       <= '0;
            last_grant <= 1'b1;
            job_id     <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            tcnt  <= tcnt_n;
            if (accept) begin
                last_grant <= grant;
                job_id     <= grant;
            end
        end
    end

    // Payload is data only: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) w_q[i] <= req_weights[grant][8*i +: 8];
            acts_q <= req_acts[grant];
        end
    end

    always_comb begin
        state_n        = state;
        idx_n          = idx;
        tcnt_n         = tcnt;
        req_ready      = 2'b00;
        wf_reset       = 1'b0;
        wf_push_col0   = 1'b0;
        wf_push_col1   = 1'b0;
        wf_data_in     = 8'h00;
        init_act_valid = 1'b0;
        init_act_data  = 16'h0000;
        start_mlp      = 1'b0;
        weights_ready  = 1'b0;
        mlp_reset      = 1'b0;
        done_valid     = 1'b0;
        done_id        = 1'b0;
        done_timeout   = 1'b0;
        busy           = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    req_ready[grant] = 1'b1;
                    state_n          = S_CLR;
                end
            end
            S_CLR: begin
                wf_reset = 1'b1;
                idx_n    = '0;
                state_n  = S_PUSH;
            end
            S_PUSH: begin
                // Push order W00, W10, W01, W11: byte index is idx with its two bits swapped.
                wf_push_col0 = ~idx[1];
                wf_push_col1 = idx[1];
                wf_data_in   = w_q[{idx[0], idx[1]}];
                idx_n        = idx + IW'(1);
                if (idx[1:0] == 2'd3) begin
                    idx_n   = '0;
                    state_n = S_ACT;
                end
            end
            S_ACT: begin
                init_act_valid = 1'b1;
                init_act_data  = acts_q[idx];
                idx_n          = idx + IW'(1);
                if (idx == IW'(NUM_ACT_ROWS - 1)) begin
                    idx_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                start_mlp     = 1'b1;
                weights_ready = 1'b1;
                tcnt_n        = '0;
                state_n       = S_WAIT;
            end
            S_WAIT: begin
                // tcnt_inc counts WAIT cycles including the current one; completion has priority.
                weights_ready = 1'b1;
                tcnt_n        = tcnt_inc;
                if (layer_complete)                          state_n = S_DONE;
                else if (tcnt_inc == TW'(TIMEOUT_CYCLES))    state_n = S_ABORT;
            end
            S_DONE: begin
                done_valid = 1'b1;
                done_id    = job_id;
                state_n    = S_DRAIN;
            end
            S_DRAIN: begin
                if (mlp_state == 4'd0 && !layer_complete) state_n = S_IDLE;
            end
            S_ABORT: begin
                mlp_reset    = 1'b1;
                done_valid   = 1'b1;
                done_timeout = 1'b1;
                done_id      = job_id;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mlp_job_scheduler.sv
// Bench for mlp_job_scheduler: table of jobs with a push/act/done scoreboard plus reset and drain sequences.
module tb_mlp_job_scheduler;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][31:0]      req_weights;
    logic [1:0][16*N-1:0]  req_acts;
    logic                  wf_reset, wf_push_col0, wf_push_col1;
    logic [7:0]            wf_data_in;
    logic                  init_act_valid;
    logic [15:0]           init_act_data;
    logic                  start_mlp, weights_ready;
    logic [3:0]            mlp_state;
    logic                  layer_complete;
    logic                  mlp_reset, done_valid, done_id, done_timeout, busy;

    mlp_job_scheduler #(.NUM_ACT_ROWS(N), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_weights(req_weights), .req_acts(req_acts),
        .wf_reset(wf_reset), .wf_push_col0(wf_push_col0), .wf_push_col1(wf_push_col1),
        .wf_data_in(wf_data_in),
        .init_act_valid(init_act_valid), .init_act_data(init_act_data),
        .start_mlp(start_mlp), .weights_ready(weights_ready),
        .mlp_state(mlp_state), .layer_complete(layer_complete),
        .mlp_reset(mlp_reset), .done_valid(done_valid), .done_id(done_id),
        .done_timeout(done_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] w;
        logic [15:0] act_base;
        int          lc;      // WAIT cycle at which layer_complete rises, -1 = never
        int          drain;   // extra cycles mlp_state stays busy after done
        logic        exp_g;
        logic        exp_to;
    } vec_t;

    vec_t vecs [8];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [8:0]  push_q [$];
    logic [15:0] act_q  [$];
    logic [1:0]  done_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wts(input logic [31:0] w, input logic r);
        return r ? (w ^ 32'h80F07F10) : w;
    endfunction

    function automatic logic [15:0] actw(input logic [15:0] b, input int k, input logic r);
        return b + 16'(k) * 16'h0101 + (r ? 16'h2000 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_payload(input vec_t v);
        for (int r = 0; r < 2; r++) begin
            req_weights[r] = wts(v.w, r[0]);
            for (int k = 0; k < N; k++) req_acts[r][16*k +: 16] = actw(v.act_base, k, r[0]);
        end
    endtask

    task automatic wait_accept(input logic [1:0] exp, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) chk("req_ready", req_ready, exp);
        else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=none required=%0h", exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        logic [31:0] wg;
        bit          ok;
        int          dexp;
        drive_payload(v);
        mlp_state      = 4'd0;
        layer_complete = 1'b0;
        req_valid      = v.valid;
        wait_accept(v.exp_g ? 2'b10 : 2'b01, ok);
        if (!ok) begin
            req_valid = 2'b00;
            return;
        end
        wg = wts(v.w, v.exp_g);
        push_q.push_back({1'b0, wg[7:0]});
        push_q.push_back({1'b0, wg[23:16]});
        push_q.push_back({1'b1, wg[15:8]});
        push_q.push_back({1'b1, wg[31:24]});
        for (int k = 0; k < N; k++) act_q.push_back(actw(v.act_base, k, v.exp_g));
        done_q.push_back({v.exp_g, v.exp_to});
        tick();
        req_valid   = 2'b00;
        req_weights = ~req_weights;
        req_acts    = ~req_acts;
        for (int k = 1; k <= 6 + N; k++) begin
            @(negedge clk);
            chk("wf_reset", wf_reset, k == 1);
            chk("start_mlp", start_mlp, k == 6 + N);
            chk("weights_ready_start", weights_ready, k == 6 + N);
            chk("busy_job", busy, 1);
            tick();
        end
        mlp_state = 4'd3;
        dexp = (v.lc >= 0) ? v.lc + 1 : 255;
        for (int j = 0; j <= dexp; j++) begin
            layer_complete = (v.lc >= 0) && (j >= v.lc);
            @(negedge clk);
            if (j < dexp) begin
                chk("done_early", done_valid, 0);
                chk("weights_ready_wait", weights_ready, 1);
            end else begin
                chk("done_valid", done_valid, 1);
                chk("done_timeout", done_timeout, v.exp_to);
                chk("mlp_reset", mlp_reset, v.exp_to);
                chk("weights_ready_done", weights_ready, 0);
            end
            tick();
        end
        if (v.exp_to) begin
            layer_complete = 1'b0;
            @(negedge clk);
            chk("abort_to_idle", busy, 0);
            mlp_state = 4'd0;
            tick();
        end else begin
            req_valid = 2'b11;
            for (int d = 0; d < v.drain; d++) begin
                mlp_state      = 4'd3;
                layer_complete = 1'b1;
                @(negedge clk);
                chk("drain_busy", busy, 1);
                chk("drain_ready", req_ready, 0);
                tick();
            end
            mlp_state      = 4'd0;
            layer_complete = 1'b1;
            @(negedge clk);
            chk("drain_lc_busy", busy, 1);
            chk("drain_lc_ready", req_ready, 0);
            tick();
            layer_complete = 1'b0;
            req_valid      = 2'b00;
            @(negedge clk);
            chk("drain_exit_busy", busy, 1);
            tick();
            @(negedge clk);
            chk("drain_idle", busy, 0);
            tick();
        end
    endtask

    // Scoreboard monitor: every push, activation write and done is matched against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wf_push_col0 || wf_push_col1) begin
                chk("push_onehot", wf_push_col0 ^ wf_push_col1, 1);
                if (push_q.size() == 0) chk("push_unexpected", {wf_push_col1, wf_data_in}, 0);
                else chk("push_data", {wf_push_col1, wf_data_in}, push_q.pop_front());
            end else begin
                chk("wf_data_idle", wf_data_in, 0);
            end
            if (init_act_valid) begin
                if (act_q.size() == 0) chk("act_unexpected", init_act_data, 0);
                else chk("act_data", init_act_data, act_q.pop_front());
            end else begin
                chk("act_data_idle", init_act_data, 0);
            end
            if (done_valid) begin
                logic [1:0] e;
                if (done_q.size() == 0) e = 2'bxx;
                else e = done_q.pop_front();
                chk("done_fields", {done_id, done_timeout, mlp_reset}, {e, e[0]});
            end
            chk("mlp_reset_alone", mlp_reset & ~done_valid, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vr;
        bit   ok;
        vecs[0] = '{2'b11, 32'h04030201, 16'h0101,  3, 2, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 32'hA1B2C3D4, 16'h1010,  1, 1, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 32'h7F80FF01, 16'h0505,  6, 0, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 32'h12345678, 16'h4444,  2, 3, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 32'hDEADBEEF, 16'h0F0F,  4, 1, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 32'h55AA33CC, 16'h2222, -1, 0, 1'b1, 1'b1};
        vecs[6] = '{2'b11, 32'h01020304, 16'h0A0B, 254, 1, 1'b0, 1'b0};
        vecs[7] = '{2'b01, 32'hCAFEF00D, 16'h7070,  0, 0, 1'b0, 1'b0};

        reset          = 1'b1;
        req_valid      = 2'b00;
        req_weights    = '0;
        req_acts       = '0;
        mlp_state      = 4'd0;
        layer_complete = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            {req_ready, wf_reset, wf_push_col0, wf_push_col1, wf_data_in, init_act_valid,
             init_act_data, start_mlp, weights_ready, mlp_reset, done_valid, done_id,
             done_timeout, busy}, 0);
        mon_en = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // Reset during the second PUSH cycle drops the job without a done.
        vr = '{2'b01, 32'h11223344, 16'h0A0A, 3, 1, 1'b0, 1'b0};
        drive_payload(vr);
        req_valid = 2'b01;
        wait_accept(2'b01, ok);
        if (ok) begin
            push_q.push_back({1'b0, 8'h44});
            push_q.push_back({1'b0, 8'h22});
            tick();
            req_valid = 2'b00;
            @(negedge clk);
            chk("rst_seq_wf_reset", wf_reset, 1);
            tick();
            @(negedge clk);
            tick();
            reset = 1'b1;
            @(negedge clk);
            tick();
            reset = 1'b0;
            @(negedge clk);
            chk("midjob_reset_outputs",
                {req_ready, wf_reset, wf_push_col0, wf_push_col1, wf_data_in, init_act_valid,
                 init_act_data, start_mlp, weights_ready, mlp_reset, done_valid, done_id,
                 done_timeout, busy}, 0);
            tick();
        end else begin
            req_valid = 2'b00;
        end

        run_job('{2'b11, 32'hF00DBEEF, 16'h1111, 5, 1, 1'b0, 1'b0});
        run_job('{2'b10, 32'h7F800102, 16'h3030, 2, 0, 1'b1, 1'b0});

        repeat (3) tick();
        chk("push_q_empty", push_q.size(), 0);
        chk("act_q_empty", act_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
